// File: rtl/ct_iu_div_pkg.sv
// Shared definitions for the IU divide-result reuse controller: FSM encoding,
// reuse-entry field layout and entry width.
package ct_iu_div_pkg;

   localparam int unsigned DIV_XLEN = 64;

   // Entry layout: {word, signed, rem, quot, divisor, dividend}
   localparam int unsigned WORD_BIT = 4 * DIV_XLEN + 1;
   localparam int unsigned SIGN_BIT = 4 * DIV_XLEN;
   localparam int unsigned REM_LSB  = 3 * DIV_XLEN;
   localparam int unsigned QUOT_LSB = 2 * DIV_XLEN;
   localparam int unsigned DVSR_LSB = DIV_XLEN;
   localparam int unsigned DVND_LSB = 0;

   function automatic int unsigned entry_w(input int unsigned xlen);
      return 2 + 4 * xlen;
   endfunction

   localparam int unsigned DIV_ENTRY_W = entry_w(DIV_XLEN);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StCmp  = 2'd1,
      StDiv  = 2'd2,
      StResp = 2'd3
   } div_state_e;

endpackage

// File: rtl/ct_iu_div_reuse_cmp.sv
// Single-entry comparator: reports whether a reuse entry holds the result for the
// given operands and mode.
module ct_iu_div_reuse_cmp
   import ct_iu_div_pkg::*;
#(
   parameter int unsigned XLEN    = DIV_XLEN,
   parameter int unsigned ENTRY_W = DIV_ENTRY_W
) (
   input  logic [ENTRY_W-1:0] entry_data,
   input  logic [XLEN-1:0]    src0,
   input  logic [XLEN-1:0]    src1,
   input  logic               op_signed,
   input  logic               op_word,
   output logic               hit
);

   // Result fields are muxed by the controller, not compared here.
   logic unused_fields;
   assign unused_fields = ^entry_data[QUOT_LSB +: 2*XLEN];

   assign hit = (entry_data[WORD_BIT] == op_word)
             && (entry_data[SIGN_BIT] == op_signed)
             && (entry_data[DVSR_LSB +: XLEN] == src1)
             && (entry_data[DVND_LSB +: XLEN] == src0);

endmodule

// File: rtl/ct_iu_div_reuse_ctrl.sv
// Divide sequencer in front of a two-entry result reuse buffer and the iterative core.
// Define CT_IU_DIV_REUSE_EN to build the entry comparators and buffer update path.
module ct_iu_div_reuse_ctrl
   import ct_iu_div_pkg::*;
#(
   parameter int unsigned XLEN    = DIV_XLEN,
   parameter int unsigned IID_W   = 7,
   parameter int unsigned ENTRY_W = entry_w(XLEN)
) (
   input  logic               div_clk,
   input  logic               cpurst_b,
   input  logic               req_vld,
   output logic               req_rdy,
   input  logic [XLEN-1:0]    req_src0,
   input  logic [XLEN-1:0]    req_src1,
   input  logic               req_signed,
   input  logic               req_word,
   input  logic               req_rem,
   input  logic [IID_W-1:0]   req_iid,
   input  logic               rtu_flush,
   input  logic               cp0_iu_div_entry_disable,
   input  logic [ENTRY_W-1:0] div_entry0_read_data,
   input  logic [ENTRY_W-1:0] div_entry1_read_data,
   output logic               div_entry0_read_vld,
   output logic               div_entry1_read_vld,
   output logic               div_entry_write_en,
   output logic [ENTRY_W-1:0] div_entry_write_data,
   output logic               core_start,
   output logic [XLEN-1:0]    core_src0,
   output logic [XLEN-1:0]    core_src1,
   output logic               core_signed,
   output logic               core_word,
   output logic               core_kill,
   input  logic               core_done,
   input  logic [XLEN-1:0]    core_quot,
   input  logic [XLEN-1:0]    core_rem,
   output logic               rslt_vld,
   output logic [XLEN-1:0]    rslt_data,
   output logic [IID_W-1:0]   rslt_iid
);

   div_state_e       state_q, state_d;
   logic [XLEN-1:0]  src0_q, src1_q, rslt_q, rslt_d;
   logic             signed_q, word_q, rem_q;
   logic [IID_W-1:0] iid_q;
   logic             hit0, hit1;
   logic [XLEN-1:0]  hit_rem, hit_quot;

   // Word results are sign-extended from bit 31 regardless of signedness.
   function automatic logic [XLEN-1:0] fmt_rslt(input logic [XLEN-1:0] val, input logic word);
      return word ? {{(XLEN-32){val[31]}}, val[31:0]} : val;
   endfunction

`ifdef CT_IU_DIV_REUSE_EN
   localparam bit ReuseEn = 1'b1;
   logic cmp_hit0, cmp_hit1;

   ct_iu_div_reuse_cmp #(.XLEN(XLEN), .ENTRY_W(ENTRY_W)) u_cmp0 (
      .entry_data (div_entry0_read_data),
      .src0       (src0_q),
      .src1       (src1_q),
      .op_signed  (signed_q),
      .op_word    (word_q),
      .hit        (cmp_hit0)
   );

   ct_iu_div_reuse_cmp #(.XLEN(XLEN), .ENTRY_W(ENTRY_W)) u_cmp1 (
      .entry_data (div_entry1_read_data),
      .src0       (src0_q),
      .src1       (src1_q),
      .op_signed  (signed_q),
      .op_word    (word_q),
      .hit        (cmp_hit1)
   );

   // Entry0 takes priority when both entries match.
   assign hit0     = cmp_hit0 & ~cp0_iu_div_entry_disable;
   assign hit1     = cmp_hit1 & ~cmp_hit0 & ~cp0_iu_div_entry_disable;
   assign hit_rem  = hit0 ? div_entry0_read_data[REM_LSB +: XLEN]
                          : div_entry1_read_data[REM_LSB +: XLEN];
   assign hit_quot = hit0 ? div_entry0_read_data[QUOT_LSB +: XLEN]
                          : div_entry1_read_data[QUOT_LSB +: XLEN];
`else
   localparam bit ReuseEn = 1'b0;
   logic unused_entry;

   assign unused_entry = ^{div_entry0_read_data, div_entry1_read_data};
   assign hit0         = 1'b0;
   assign hit1         = 1'b0;
   assign hit_rem      = '0;
   assign hit_quot     = '0;
`endif

   always_comb begin
      state_d             = state_q;
      rslt_d              = rslt_q;
      div_entry0_read_vld = 1'b0;
      div_entry1_read_vld = 1'b0;
      div_entry_write_en  = 1'b0;
      core_start          = 1'b0;
      core_kill           = 1'b0;
      rslt_vld            = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (req_vld) state_d = StCmp;
         end
         StCmp: begin
            if (rtu_flush) begin
               state_d = StIdle;
            end else if (hit0 || hit1) begin
               div_entry0_read_vld = hit0;
               div_entry1_read_vld = hit1;
               rslt_d              = fmt_rslt(rem_q ? hit_rem : hit_quot, word_q);
               state_d             = StResp;
            end else begin
               core_start = 1'b1;
               state_d    = StDiv;
            end
         end
         StDiv: begin
            if (rtu_flush) begin
               core_kill = 1'b1;
               state_d   = StIdle;
            end else if (core_done) begin
               div_entry_write_en = ReuseEn & ~cp0_iu_div_entry_disable;
               rslt_d             = fmt_rslt(rem_q ? core_rem : core_quot, word_q);
               state_d            = StResp;
            end
         end
         StResp: begin
            rslt_vld = ~rtu_flush;
            state_d  = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign div_entry_write_data = div_entry_write_en
                               ? {word_q, signed_q, core_rem, core_quot, src1_q, src0_q} : '0;

   assign req_rdy     = (state_q == StIdle);
   assign core_src0   = src0_q;
   assign core_src1   = src1_q;
   assign core_signed = signed_q;
   assign core_word   = word_q;
   assign rslt_data   = rslt_q;
   assign rslt_iid    = iid_q;

   always_ff @(posedge div_clk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         state_q  <= StIdle;
         src0_q   <= '0;
         src1_q   <= '0;
         signed_q <= 1'b0;
         word_q   <= 1'b0;
         rem_q    <= 1'b0;
         iid_q    <= '0;
         rslt_q   <= '0;
      end else begin
         state_q <= state_d;
         rslt_q  <= rslt_d;
         if (req_vld && req_rdy) begin
            src0_q   <= req_src0;
            src1_q   <= req_src1;
            signed_q <= req_signed;
            word_q   <= req_word;
            rem_q    <= req_rem;
            iid_q    <= req_iid;
         end
      end
   end

endmodule
